int_mult_pool_arb: RTL and testbench
====================================

Name: int_mult_pool_arb

Overview:
- Parametrised successor of the shared integer-multiplier pool used by the FFT and NTT datapaths.
- Holds NUM_LANES pipelined OPW x OPW multipliers and arbitrates cycle-by-cycle between two requestors using valid/ready handshakes.
- Arbitration is fixed-priority or round-robin, with optional burst hold.
- Each issue carries an owner tag and lane mask through the pipeline, so results come back tagged after exactly MULT_LATENCY cycles. No external grant signal is needed.

Parameters:
- NUM_LANES, 4, number of parallel multiplier lanes.
- OPW, 54, operand width; product is 2*OPW bits.
- LOW_W, 24, width of result_low (product[LOW_W-1:0]).
- MULT_LATENCY, 4, cycles from accepted issue to res_valid; legal range 2..8.
- ARB_MODE, 1, 0 = fixed priority (FFT wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fft_valid  in  1  FFT request
- fft_hold  in  1  FFT requests to keep the grant on its next request (burst)
- fft_mask  in  NUM_LANES  FFT lanes carrying valid operands
- a_fft, b_fft  in  NUM_LANES x OPW  FFT operands
- fft_ready  out  1  FFT request accepted this cycle
- ntt_valid, ntt_hold, ntt_mask, a_ntt, b_ntt  in  as FFT  NTT request
- ntt_ready  out  1  NTT request accepted this cycle
- res_valid  out  1  result bundle valid
- res_owner  out  1  1 = FFT, 0 = NTT
- res_mask  out  NUM_LANES  lane mask of the issue
- result  out  NUM_LANES x 2*OPW  full products
- result_low  out  NUM_LANES x LOW_W  low product bits
- busy  out  1  any issue in flight in the pipeline

Behaviour:
- Reset is asynchronous. Cleared by reset: pipeline valid/tag/mask registers, last_owner (reset value 0 = NTT), hold_owner flag, and all outputs (res_valid, res_owner, res_mask, result, result_low, busy).
- Reset mid-operation discards every in-flight issue. No res_valid appears afterwards for issues accepted before reset.
- fft_ready and ntt_ready are combinational from valids and arbiter state. At most one is high per cycle. A requestor's ready is only high when its valid is high.
- Accept means valid && ready. Operands, mask and owner are captured on that clk edge. There is no result backpressure; consumers always accept.
- Grant decision when both valids are high, in priority order:
  - If hold_owner is set, the held owner wins.
  - Otherwise, with ARB_MODE=0, FFT wins.
  - Otherwise, with ARB_MODE=1, the requestor opposite last_owner wins.
- When only one valid is high, that requestor is granted.
- last_owner updates on every accept.
- hold_owner is set on accept when the winner's *_hold is high, and cleared on accept when *_hold is low.
- hold_owner is also cleared on any cycle where the held requestor's valid is low. A held requestor that drops valid therefore loses the hold.
- Masked-off lanes (mask bit 0) have their operand registers forced to zero. Their result and result_low are 0.
- Mask of all zeros is still accepted and tagged, and produces res_valid with res_mask = 0.
- Latency: accept at edge N gives res_valid high during the cycle after edge N+MULT_LATENCY-1. Equivalently, it is registered at the MULT_LATENCY-th edge counting the accept edge as 1.
- Throughput: one accept per cycle, back-to-back, with either owner mixed freely. Results are in issue order.
- Arithmetic: unsigned. result = a*b, 2*OPW bits, no truncation. result_low = result[LOW_W-1:0].
- The multiply is written behaviourally, with registers retimed across MULT_LATENCY stages. Valid, owner and mask travel in a parallel shift register of depth MULT_LATENCY.
- busy = OR of all valid bits in the pipeline, registered.
- When neither valid is high, no issue occurs, last_owner is unchanged, and an empty slot (valid 0) enters the pipeline.

Test Plan:
- Single FFT issue: a=3, b=5, mask=4'b1111, all lanes, no NTT request -> fft_ready=1; res_valid exactly 4 cycles later; res_owner=1; result=15; result_low=15.
- Max operands: a=b=2^54-1, all lanes -> result = 2^108 - 2^55 + 1; result_low = 24'h000001.
- Contention in round-robin, both valid for 6 cycles, no hold -> accepted owners alternate F,N,F,N,F,N; first is FFT because last_owner resets to NTT. res_owner sequence matches, 4 cycles delayed.
- Same contention with ARB_MODE=0 -> FFT accepted all 6 cycles, ntt_ready held 0. With ARB_MODE=1 and ntt_hold=1 after one NTT grant -> NTT keeps the grant until ntt_hold drops.
- Masked issue: NTT mask=4'b0101 with lanes 1 and 3 holding nonzero operands -> result lanes 1 and 3 = 0; res_mask=4'b0101.
- Reset mid-flight: 3 issues accepted, rst pulsed 2 cycles after the first -> res_valid never asserts; busy=0 immediately; a new issue after reset completes normally with 4-cycle latency.

Source files
------------

// File: rtl/int_mult_pool_arb.sv
// Shared integer-multiplier pool: NUM_LANES pipelined OPW x OPW multipliers arbitrated
// between an FFT and an NTT requestor. Each issue carries owner and lane mask alongside
// the datapath so results return tagged after exactly MULT_LATENCY cycles.
module int_mult_pool_arb #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned OPW          = 54,
    parameter int unsigned LOW_W        = 24,
    parameter int unsigned MULT_LATENCY = 4,
    parameter int unsigned ARB_MODE     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fft_valid,
    input  logic                           fft_hold,
    input  logic [NUM_LANES-1:0]           fft_mask,
    input  logic [NUM_LANES*OPW-1:0]       a_fft,
    input  logic [NUM_LANES*OPW-1:0]       b_fft,
    output logic                           fft_ready,
    input  logic                           ntt_valid,
    input  logic                           ntt_hold,
    input  logic [NUM_LANES-1:0]           ntt_mask,
    input  logic [NUM_LANES*OPW-1:0]       a_ntt,
    input  logic [NUM_LANES*OPW-1:0]       b_ntt,
    output logic                           ntt_ready,
    output logic                           res_valid,
    output logic                           res_owner,
    output logic [NUM_LANES-1:0]           res_mask,
    output logic [NUM_LANES*2*OPW-1:0]     result,
    output logic [NUM_LANES*LOW_W-1:0]     result_low,
    output logic                           busy
);

    localparam int unsigned PW = 2 * OPW;
    // Operand registers take one stage; the remaining stages hold the product.
    localparam int unsigned NS = MULT_LATENCY - 1;

    // Arbiter state: last_owner 1 = FFT, 0 = NTT; hold_owner keeps last_owner granted.
    logic last_owner_q, last_owner_d;
    logic hold_owner_q, hold_owner_d;
    logic pick_fft, accept, held_valid;

    logic [OPW-1:0] op_a_q [NUM_LANES];
    logic [OPW-1:0] op_a_d [NUM_LANES];
    logic [OPW-1:0] op_b_q [NUM_LANES];
    logic [OPW-1:0] op_b_d [NUM_LANES];

    logic [PW-1:0] prod_q [NS][NUM_LANES];
    logic [PW-1:0] prod_d [NS][NUM_LANES];

    logic [MULT_LATENCY-1:0] vld_q, vld_d;
    logic [MULT_LATENCY-1:0] own_q, own_d;
    logic [NUM_LANES-1:0]    msk_q [MULT_LATENCY];
    logic [NUM_LANES-1:0]    msk_d [MULT_LATENCY];
    logic                    busy_q, busy_d;

    // Grant decision, readies and next arbiter state.
    always_comb begin
        pick_fft = 1'b0;
        if (hold_owner_q) begin
            pick_fft = last_owner_q;
        end else if (ARB_MODE == 0) begin
            pick_fft = 1'b1;
        end else begin
            pick_fft = ~last_owner_q;
        end
        fft_ready  = fft_valid & (~ntt_valid | pick_fft);
        ntt_ready  = ntt_valid & (~fft_valid | ~pick_fft);
        accept     = fft_ready | ntt_ready;
        held_valid = last_owner_q ? fft_valid : ntt_valid;

        last_owner_d = accept ? fft_ready : last_owner_q;
        // A held requestor that drops valid loses the hold.
        hold_owner_d = hold_owner_q & held_valid;
        if (accept) begin
            hold_owner_d = fft_ready ? fft_hold : ntt_hold;
        end
    end

    // Operand capture on accept; masked-off lanes are forced to zero.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            op_a_d[i] = op_a_q[i];
            op_b_d[i] = op_b_q[i];
            if (fft_ready) begin
                op_a_d[i] = fft_mask[i] ? a_fft[i*OPW +: OPW] : '0;
                op_b_d[i] = fft_mask[i] ? b_fft[i*OPW +: OPW] : '0;
            end else if (ntt_ready) begin
                op_a_d[i] = ntt_mask[i] ? a_ntt[i*OPW +: OPW] : '0;
                op_b_d[i] = ntt_mask[i] ? b_ntt[i*OPW +: OPW] : '0;
            end
        end
    end

    // Behavioural multiply followed by retiming stages.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_d[0][i] = PW'(op_a_q[i]) * PW'(op_b_q[i]);
        end
        for (int s = 1; s < NS; s++) begin
            prod_d[s] = prod_q[s-1];
        end
    end

    // Valid/owner/mask shift register running parallel to the datapath.
    always_comb begin
        vld_d[0] = accept;
        own_d[0] = fft_ready;
        msk_d[0] = fft_ready ? fft_mask : (ntt_ready ? ntt_mask : '0);
        for (int s = 1; s < MULT_LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            own_d[s] = own_q[s-1];
            msk_d[s] = msk_q[s-1];
        end
        busy_d = |vld_d;
    end

    // State registers; reset discards every in-flight issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= 1'b0;
            hold_owner_q <= 1'b0;
            vld_q        <= '0;
            own_q        <= '0;
            busy_q       <= 1'b0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                msk_q[s] <= '0;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                op_a_q[i] <= '0;
                op_b_q[i] <= '0;
            end
            for (int s = 0; s < NS; s++) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    prod_q[s][i] <= '0;
                end
            end
        end else begin
            last_owner_q <= last_owner_d;
            hold_owner_q <= hold_owner_d;
            vld_q        <= vld_d;
            own_q        <= own_d;
            busy_q       <= busy_d;
            msk_q        <= msk_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            prod_q       <= prod_d;
        end
    end

    assign res_valid = vld_q[MULT_LATENCY-1];
    assign res_owner = own_q[MULT_LATENCY-1];
    assign res_mask  = msk_q[MULT_LATENCY-1];
    assign busy      = busy_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_out
        assign result[i*PW +: PW]          = prod_q[NS-1][i];
        assign result_low[i*LOW_W +: LOW_W] = prod_q[NS-1][i][LOW_W-1:0];
    end

endmodule

// File: tb/tb_int_mult_pool_arb.sv
// Bench for int_mult_pool_arb: fixed-priority and round-robin instances share stimulus and
// are checked against a transaction-level model (grant rule plus a queue of due results).
module tb_int_mult_pool_arb;

    localparam int L   = 4;
    localparam int NL  = 4;
    localparam int OPW = 54;
    localparam int LW  = 24;
    localparam int PW  = 108;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              fv, fh, nv, nh;
    logic [NL-1:0]     fm, nm;
    logic [NL*OPW-1:0] af, bf, an, bn;

    logic [1:0]             fr, nr, rv, ro, bz;
    logic [1:0][NL-1:0]     rm;
    logic [1:0][NL*PW-1:0]  res;
    logic [1:0][NL*LW-1:0]  rl;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        int_mult_pool_arb #(
            .NUM_LANES(NL), .OPW(OPW), .LOW_W(LW), .MULT_LATENCY(L), .ARB_MODE(m)
        ) dut (
            .clk(clk), .rst(rst),
            .fft_valid(fv), .fft_hold(fh), .fft_mask(fm), .a_fft(af), .b_fft(bf),
            .fft_ready(fr[m]),
            .ntt_valid(nv), .ntt_hold(nh), .ntt_mask(nm), .a_ntt(an), .b_ntt(bn),
            .ntt_ready(nr[m]),
            .res_valid(rv[m]), .res_owner(ro[m]), .res_mask(rm[m]),
            .result(res[m]), .result_low(rl[m]), .busy(bz[m])
        );
    end

    typedef struct packed {
        logic [1:0]            own;
        logic [1:0][NL-1:0]    msk;
        logic [1:0][NL*PW-1:0] res;
        logic [1:0][NL*LW-1:0] low;
        int                    due;
    } ent_t;

    ent_t q[$];
    int   cyc;
    int   total;
    int   bad;
    logic [1:0] lo, hd;   // model: last owner (1 = FFT) and hold flag, per arbitration mode

    task automatic chk(input string tag, input int m, input logic [NL*PW-1:0] got,
                       input logic [NL*PW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s mode=%0d cyc=%0d got=%h exp=%h", tag, m, cyc, got, exp);
        end
    endtask

    // Model grant when both request: held owner, else FFT (mode 0), else opposite of last.
    function automatic logic wins_fft(input int m);
        if (fv && nv) begin
            if (hd[m]) return lo[m];
            if (m == 0) return 1'b1;
            return ~lo[m];
        end
        return fv;
    endfunction

    function automatic logic [NL*PW-1:0] prods(input logic [NL*OPW-1:0] a, b,
                                               input logic [NL-1:0] mk);
        logic [NL*PW-1:0] p;
        logic [PW-1:0] x, y;
        for (int i = 0; i < NL; i++) begin
            x = PW'(a[i*OPW +: OPW]);
            y = PW'(b[i*OPW +: OPW]);
            p[i*PW +: PW] = mk[i] ? x * y : '0;
        end
        return p;
    endfunction

    function automatic logic [NL*LW-1:0] lows(input logic [NL*PW-1:0] p);
        logic [NL*LW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = p[i*PW +: LW];
        return r;
    endfunction

    function automatic logic [NL*OPW-1:0] rnd_ops();
        logic [NL*OPW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*OPW +: OPW] = OPW'({$urandom(), $urandom()});
        return r;
    endfunction

    // One clock: check readies and outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [1:0] g;
        logic acc, hv;
        ent_t e;
        @(negedge clk);
        acc = fv | nv;
        hv  = (q.size() > 0) && (q[0].due == cyc);
        for (int m = 0; m < 2; m++) begin
            g[m] = wins_fft(m);
            chk("fft_ready", m, fr[m], acc & g[m]);
            chk("ntt_ready", m, nr[m], acc & ~g[m]);
            chk("res_valid", m, rv[m], hv);
            chk("busy", m, bz[m], q.size() > 0);
            if (hv) begin
                chk("res_owner", m, ro[m], q[0].own[m]);
                chk("res_mask", m, rm[m], q[0].msk[m]);
                chk("result", m, res[m], q[0].res[m]);
                chk("result_low", m, rl[m], q[0].low[m]);
            end
        end
        if (hv) void'(q.pop_front());
        @(posedge clk);
        cyc++;
        if (acc) begin
            e.due = cyc + L - 1;
            for (int m = 0; m < 2; m++) begin
                e.own[m] = g[m];
                e.msk[m] = g[m] ? fm : nm;
                e.res[m] = g[m] ? prods(af, bf, fm) : prods(an, bn, nm);
                e.low[m] = lows(e.res[m]);
                lo[m]    = g[m];
                hd[m]    = g[m] ? fh : nh;
            end
            q.push_back(e);
        end else begin
            hd = '0;
        end
        #1;
    endtask

    task automatic set_f(input logic v, h, input logic [NL-1:0] m,
                         input logic [NL*OPW-1:0] a, b);
        fv = v; fh = h; fm = m; af = a; bf = b;
    endtask

    task automatic set_n(input logic v, h, input logic [NL-1:0] m,
                         input logic [NL*OPW-1:0] a, b);
        nv = v; nh = h; nm = m; an = a; bn = b;
    endtask

    task automatic idle(input int n);
        set_f(1'b0, 1'b0, '0, '0, '0);
        set_n(1'b0, 1'b0, '0, '0, '0);
        repeat (n) step();
    endtask

    // Asynchronous reset pulse of two edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        set_f(1'b0, 1'b0, '0, '0, '0);
        set_n(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        q.delete();
        lo = '0;
        hd = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_res_valid", m, rv[m], 1'b0);
            chk("rst_busy", m, bz[m], 1'b0);
            chk("rst_result", m, res[m], '0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        do_reset();

        // Single FFT issue, 3*5 on all lanes.
        set_f(1'b1, 1'b0, 4'hF, {NL{54'd3}}, {NL{54'd5}});
        step();
        idle(5);

        // Maximum operands.
        set_f(1'b1, 1'b0, 4'hF, {NL{54'h3F_FFFF_FFFF_FFFF}}, {NL{54'h3F_FFFF_FFFF_FFFF}});
        step();
        idle(5);

        // Contention from reset, no hold.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_f(1'b1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
            set_n(1'b1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
            step();
        end
        idle(5);

        // NTT burst hold, then release.
        for (int i = 0; i < 8; i++) begin
            set_f(1'b1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
            set_n(1'b1, i < 5, 4'hF, rnd_ops(), rnd_ops());
            step();
        end
        idle(5);

        // Masked NTT issue with nonzero operands in masked-off lanes, then all-zero mask.
        set_n(1'b1, 1'b0, 4'b0101, {54'd7, 54'd9, 54'd11, 54'd13},
              {54'd17, 54'd19, 54'd23, 54'd29});
        step();
        set_n(1'b0, 1'b0, '0, '0, '0);
        set_f(1'b1, 1'b0, 4'b0000, rnd_ops(), rnd_ops());
        step();
        idle(5);

        // Random traffic including holds, dropped valids and partial masks.
        for (int i = 0; i < 300; i++) begin
            set_f(1'($urandom_range(0, 3) != 0), 1'($urandom()), 4'($urandom()),
                  rnd_ops(), rnd_ops());
            set_n(1'($urandom_range(0, 3) != 0), 1'($urandom()), 4'($urandom()),
                  rnd_ops(), rnd_ops());
            step();
        end
        idle(6);

        // Reset with three issues in flight; none may complete.
        for (int i = 0; i < 3; i++) begin
            set_f(i != 1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
            set_n(i == 1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
            step();
        end
        do_reset();
        idle(6);
        set_n(1'b1, 1'b0, 4'hF, rnd_ops(), rnd_ops());
        step();
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
